// File: rtl/register_scoreboard.sv
// Read-after-write scoreboard: one pending-write counter per architectural register,
// with a same-cycle retire bypass so a writeback can release a dependent in its own cycle.
module register_scoreboard #(
    parameter int NUM_REGISTERS           = 32,
    parameter int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS),
    parameter int MAX_PENDING             = 3,
    parameter int COUNT_WIDTH             = $clog2(MAX_PENDING + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               issue_valid,
    output logic                               issue_stall,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_rs1,
    input  logic                               issue_rs1_used,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_rs2,
    input  logic                               issue_rs2_used,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_rd,
    input  logic                               issue_rd_valid,
    input  logic                               write_activate,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register,
    input  logic                               flush,
    output logic [NUM_REGISTERS-1:0]           busy_mask,
    output logic                               idle,
    output logic                               underflow_error
);

    localparam logic [COUNT_WIDTH-1:0] SAT = COUNT_WIDTH'(MAX_PENDING);

    logic [COUNT_WIDTH-1:0]   count      [NUM_REGISTERS];
    logic [COUNT_WIDTH-1:0]   eff        [NUM_REGISTERS];
    logic [COUNT_WIDTH-1:0]   count_next [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] ret_hit;
    logic                     rs1_hazard;
    logic                     rs2_hazard;
    logic                     rd_full;
    logic                     issue_xfer;
    logic                     underflow_set;

    // A retire against an empty counter leaves eff at 0; underflow_set flags it.
    always_comb begin
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            ret_hit[r] = write_activate && !flush && (r != 0) &&
                         (write_register == REGISTER_INDEXING_WIDTH'(r));
            eff[r]     = (ret_hit[r] && count[r] != '0) ? count[r] - COUNT_WIDTH'(1) : count[r];
        end
    end

    assign rs1_hazard = issue_rs1_used && issue_rs1 != '0 && eff[issue_rs1] != '0;
    assign rs2_hazard = issue_rs2_used && issue_rs2 != '0 && eff[issue_rs2] != '0;
    assign rd_full    = issue_rd_valid && issue_rd != '0 && eff[issue_rd] == SAT;

    // Handshake: an instruction transfers when issue_valid && !issue_stall. issue_stall
    // never looks at issue_valid, and decode holds its fields stable while stalled.
    assign issue_stall = !rst || flush || rs1_hazard || rs2_hazard || rd_full;
    assign issue_xfer  = issue_valid && !issue_stall;

    assign underflow_set = write_activate && !flush && write_register != '0 &&
                           count[write_register] == '0;

    always_comb begin
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            if (r == 0) begin
                count_next[r] = '0;
            end else begin
                count_next[r] = eff[r] + COUNT_WIDTH'(issue_xfer && issue_rd_valid &&
                                (issue_rd == REGISTER_INDEXING_WIDTH'(r)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                count[r] <= '0;
            end
            underflow_error <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                count[r] <= flush ? '0 : count_next[r];
            end
            if (underflow_set) begin
                underflow_error <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            busy_mask[r] = count[r] != '0;
        end
    end

    assign idle = busy_mask == '0;

endmodule
